ofs_plat_ccip_wr_rsp_packer: RTL

OFS_PLAT_CCIP_WR_RSP_PACKER -- requirements
Module: ofs_plat_ccip_wr_rsp_packer

---
 rtl/ofs_plat_ccip_wr_rsp_packer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ofs_plat_ccip_wr_rsp_packer.sv
// Packs per-line CCI-P c1 write responses into one packed response per multi-line write.
// Optional build macro OFS_PLAT_CCIP_WR_RSP_PACKER_CHECK_EN adds busy tracking and a sticky err flag.
module ofs_plat_ccip_wr_rsp_packer #(
    parameter int IDX_WIDTH = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tx_valid,
    input  logic        tx_sop,
    input  logic [3:0]  tx_req_type,
    input  logic [1:0]  tx_cl_len,
    input  logic [15:0] tx_mdata,
    input  logic        rx_valid,
    input  logic [3:0]  rx_resp_type,
    input  logic        rx_format,
    input  logic [1:0]  rx_cl_num,
    input  logic [15:0] rx_mdata,
    output logic        out_valid,
    output logic [3:0]  out_resp_type,
    output logic        out_format,
    output logic [1:0]  out_cl_num,
    output logic [15:0] out_mdata,
    output logic        err
);

    localparam int DEPTH = 1 << IDX_WIDTH;

    localparam logic [3:0] EREQ_WRLINE_I = 4'h0;
    localparam logic [3:0] EREQ_WRLINE_M = 4'h1;
    localparam logic [3:0] ERSP_WRLINE   = 4'h1;

    logic [IDX_WIDTH-1:0] tx_idx;
    logic [IDX_WIDTH-1:0] rx_idx;
    logic                 tx_wr_sop;
    logic                 rx_wr;
    logic                 rx_unpacked;
    logic                 rx_last;
    logic                 rx_emit;
    logic [1:0]           rx_len;
    logic [1:0]           rx_cnt;
    logic                 unused_mdata_hi;

    // Per-index expected line count (len) and lines seen so far (cnt).
    logic [1:0] len_q [DEPTH];
    logic [1:0] cnt_q [DEPTH];

    logic        out_valid_q;
    logic [3:0]  out_resp_type_q;
    logic        out_format_q;
    logic [1:0]  out_cl_num_q;
    logic [15:0] out_mdata_q;
    logic        out_format_d;
    logic [1:0]  out_cl_num_d;

    assign tx_idx = tx_mdata[IDX_WIDTH-1:0];
    assign rx_idx = rx_mdata[IDX_WIDTH-1:0];
    assign unused_mdata_hi = ^tx_mdata[15:IDX_WIDTH];

    assign tx_wr_sop = tx_valid && tx_sop &&
                       ((tx_req_type == EREQ_WRLINE_I) || (tx_req_type == EREQ_WRLINE_M));
    assign rx_wr       = rx_valid && (rx_resp_type == ERSP_WRLINE);
    assign rx_unpacked = rx_wr && !rx_format;

    assign rx_len  = len_q[rx_idx];
    assign rx_cnt  = cnt_q[rx_idx];
    assign rx_last = rx_unpacked && (rx_cnt == rx_len);
    // Everything except a non-final unpacked write line produces an output.
    assign rx_emit = rx_valid && (!rx_unpacked || rx_last);

    assign out_format_d = rx_last ? 1'b1   : rx_format;
    assign out_cl_num_d = rx_last ? rx_len : rx_cl_num;

    always_ff @(posedge clk) begin
        if (tx_wr_sop) begin
            len_q[tx_idx] <= tx_cl_len;
        end
    end

    // RX update is written last so it wins when both hit the same index.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (tx_wr_sop) begin
                cnt_q[tx_idx] <= '0;
            end
            if (rx_unpacked) begin
                cnt_q[rx_idx] <= rx_last ? 2'd0 : rx_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rx_emit;
        end
    end

    always_ff @(posedge clk) begin
        out_resp_type_q <= rx_resp_type;
        out_format_q    <= out_format_d;
        out_cl_num_q    <= out_cl_num_d;
        out_mdata_q     <= rx_mdata;
    end

    assign out_valid     = out_valid_q;
    assign out_resp_type = out_resp_type_q;
    assign out_format    = out_format_q;
    assign out_cl_num    = out_cl_num_q;
    assign out_mdata     = out_mdata_q;

`ifdef OFS_PLAT_CCIP_WR_RSP_PACKER_CHECK_EN
    logic busy_q [DEPTH];
    logic err_q;
    logic err_d;

    assign err_d = (rx_wr && !busy_q[rx_idx]) || (tx_wr_sop && busy_q[tx_idx]);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i] <= 1'b0;
            end
        end else begin
            if (tx_wr_sop) begin
                busy_q[tx_idx] <= 1'b1;
            end
            if (rx_wr && (rx_format || rx_last)) begin
                busy_q[rx_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (err_d) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
